led_fifo: RTL and testbench

Switch-driven 16-entry x 8-bit FIFO demonstrator for the FPGA board top level. Board switches supply write data and push/pop/clear requests; red LEDs show the last popped byte, fill level and status flags. One seven-segment digit shows the hex value of the low nibble of the last popped byte. Module name is `led_fifo`; it replaces the `led` top in the FIFO lab.

---
 rtl/led_fifo_if.sv | 11 +
 rtl/led_fifo.sv | 113 +++++++++++
 tb/tb_led_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/led_fifo_if.sv
// Board-facing signal bundle for the FIFO demonstrator: switches in,
// red LEDs and one seven-segment digit out.
interface led_fifo_if;
  logic [15:0] sw;
  logic [15:0] ledr;
  logic [7:0]  seg0;

  // master drives the switches (board / bench), slave is the FIFO core
  modport master (output sw, input ledr, input seg0);
  modport slave  (input sw, output ledr, output seg0);
endinterface

// File: rtl/led_fifo.sv
// Switch-driven FIFO demonstrator. Switch bits are synchronized and
// edge-detected into single-cycle push/pop/clear strobes. The strobes have
// no backpressure: an operation that cannot be honoured (push while full
// without a pop, pop while empty) is dropped and sets a sticky error flag.
module led_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  led_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [10:0]      s1, s2, s3;
  logic             push_p, pop_p, clr_p;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dout;
  logic             error;
  logic             empty, full;
  logic [6:0]       glyph;
  logic             unused_sw;

  assign unused_sw = ^bus.sw[15:11];

  // Two-flop synchronizer plus one extra stage for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= bus.sw[10:0];
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign push_p = s2[8]  & ~s3[8];
  assign pop_p  = s2[9]  & ~s3[9];
  assign clr_p  = s2[10] & ~s3[10];

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Clear wins; a pop alongside a push lets a full FIFO still accept data
  assign do_push = push_p & ~clr_p & (~full | pop_p);
  assign do_pop  = pop_p  & ~clr_p & ~empty;

  // Storage array needs no reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= s2[WIDTH-1:0];
  end

  // Pointers, fill count, last popped byte and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      dout  <= '0;
      error <= 1'b0;
    end else if (clr_p) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      error <= 1'b0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) begin
        rp   <= rp + AW'(1);
        dout <= mem[rp];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if ((push_p & full & ~pop_p) | (pop_p & empty)) error <= 1'b1;
    end
  end

  // Hex glyph of the low nibble of the last popped byte (segments g..a)
  always_comb begin
    glyph = 7'h7F;
    case (dout[3:0])
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end

  assign bus.ledr = {error, full, empty, count, dout};
  assign bus.seg0 = {~full, glyph};
endmodule

// File: tb/tb_led_fifo.sv
// Directed bench for led_fifo: drives switch toggles and compares LEDs and
// the seven-segment digit against hand-computed values.
module tb_led_fifo;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  led_fifo_if bus ();

  led_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Raise op bits {clear,pop,push} with data, wait until the result lands,
  // then drop the op bits (data held) and let the edge detector settle.
  task automatic do_op(input logic [7:0] data, input logic [2:0] ops);
    @(negedge clk);
    bus.sw = {5'b0, ops, data};
    repeat (3) @(posedge clk);
    #1;
    bus.sw = {5'b0, 3'b000, data};
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.sw = '0;
    #2;
    check("reset_ledr", bus.ledr, 16'h2000);
    check("reset_seg0", bus.seg0, 8'hC0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // single push with latency check
    @(negedge clk);
    bus.sw = {5'b0, 3'b001, 8'hA5};
    repeat (2) @(posedge clk);
    #1;
    check("push_lat_k1", bus.ledr, 16'h2000);
    @(posedge clk);
    #1;
    check("push_lat_k2", bus.ledr, 16'h0100);
    bus.sw = {5'b0, 3'b000, 8'hA5};
    repeat (3) @(posedge clk);
    #1;
    check("push_release", bus.ledr, 16'h0100);

    // single pop
    do_op(8'hA5, 3'b010);
    check("pop_ledr", bus.ledr, 16'h20A5);
    check("pop_seg0", bus.seg0, 8'h92);

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      do_op(8'(i), 3'b001);
      check("fill_count", {11'b0, bus.ledr[12:8]}, 16'(i + 1));
    end
    check("full_ledr", bus.ledr, 16'h50A5);
    check("full_seg0", bus.seg0, 8'h12);

    // overflow
    do_op(8'h77, 3'b001);
    check("overflow_ledr", bus.ledr, 16'hD0A5);

    // drain in order
    for (int i = 0; i < 16; i++) begin
      do_op(8'h77, 3'b010);
      check("drain_data", {8'b0, bus.ledr[7:0]}, 16'(i));
    end
    check("drained_ledr", bus.ledr, 16'hA00F);
    check("drained_seg0", bus.seg0, 8'h8E);

    // clear, underflow, clear
    do_op(8'h00, 3'b100);
    check("clear1_ledr", bus.ledr, 16'h200F);
    do_op(8'h00, 3'b010);
    check("underflow_ledr", bus.ledr, 16'hA00F);
    do_op(8'h00, 3'b100);
    check("clear2_ledr", bus.ledr, 16'h200F);

    // simultaneous push+pop at count 3
    do_op(8'h11, 3'b001);
    do_op(8'h22, 3'b001);
    do_op(8'h33, 3'b001);
    check("three_ledr", bus.ledr, 16'h030F);
    do_op(8'h44, 3'b011);
    check("simul_mid_ledr", bus.ledr, 16'h0311);
    check("simul_mid_seg0", bus.seg0, 8'hF9);
    do_op(8'h00, 3'b010);
    check("pop_22", bus.ledr, 16'h0222);
    do_op(8'h00, 3'b010);
    check("pop_33", bus.ledr, 16'h0133);
    do_op(8'h00, 3'b010);
    check("pop_44", bus.ledr, 16'h2044);

    // simultaneous push+pop when empty
    do_op(8'h55, 3'b011);
    check("simul_empty_ledr", bus.ledr, 16'h8144);

    // clear, then a long-held push switch acts once
    do_op(8'h00, 3'b100);
    check("clear3_ledr", bus.ledr, 16'h2044);
    @(negedge clk);
    bus.sw = {5'b0, 3'b001, 8'h66};
    repeat (100) @(posedge clk);
    #1;
    check("held_push_ledr", bus.ledr, 16'h0144);
    bus.sw = {5'b0, 3'b000, 8'h66};
    repeat (3) @(posedge clk);
    #1;

    // fill to 16, then simultaneous push+pop while full
    for (int i = 1; i < 16; i++) do_op(8'(8'h80 + i), 3'b001);
    check("refill_ledr", bus.ledr, 16'h5044);
    do_op(8'h99, 3'b011);
    check("simul_full_ledr", bus.ledr, 16'h5066);
    check("simul_full_seg0", bus.seg0, 8'h02);
    do_op(8'h00, 3'b010);
    check("after_full_pop", bus.ledr, 16'h0F81);

    // asynchronous reset mid-cycle, no clock edge needed
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_ledr", bus.ledr, 16'h2000);
    check("async_rst_seg0", bus.seg0, 8'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
